// File: rtl/hilo_div_unit.sv
// hilo_div_unit: iterative 32-bit radix-2 restoring divider serving DIV/DIVU
// for the HILO functional unit. Fixed 33-cycle latency for nonzero divisors,
// result presented as {remainder, quotient} with a start/ready handshake.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_DIVZERO = 2'b01,
    S_ON      = 2'b10,
    S_END     = 2'b11
  } state_t;

  state_t             state_reg, state_next;
  logic [4:0]         cnt_reg;
  logic [2*WIDTH:0]   work_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic               sdiv_reg, sign1_reg, sign2_reg;

  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [2*WIDTH:0]   shifted, step;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               last_step;

  // Operand magnitudes: negate only when signed and negative; -2^31 stays
  // representable because magnitudes live in the unsigned 32-bit space.
  always_comb begin
    dvd_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    dvs_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  // One restoring step: shift left, trial-subtract the divisor from the top
  // 33 bits, keep the difference and set the quotient bit when it fits.
  always_comb begin
    shifted = work_reg << 1;
    diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_reg};
    step    = shifted;
    if (shifted[2*WIDTH:WIDTH] >= {1'b0, divisor_reg}) begin
      step = {diff, shifted[WIDTH-1:1], 1'b1};
    end
    quot_fix  = (sdiv_reg && (sign1_reg != sign2_reg)) ? (~step[WIDTH-1:0] + 1'b1)
                                                       : step[WIDTH-1:0];
    rem_fix   = (sdiv_reg && sign1_reg) ? (~step[2*WIDTH-1:WIDTH] + 1'b1)
                                        : step[2*WIDTH-1:WIDTH];
    last_step = (cnt_reg == 5'd31);
  end

  // Next-state logic for the handshake FSM.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          state_next = (opdata2_i == '0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: state_next = S_END;
      S_ON: begin
        if (annul_i) begin
          state_next = S_IDLE;
        end else if (last_step) begin
          state_next = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: operand capture, iteration, sign correction and output regs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_reg     <= '0;
      work_reg    <= '0;
      divisor_reg <= '0;
      sdiv_reg    <= 1'b0;
      sign1_reg   <= 1'b0;
      sign2_reg   <= 1'b0;
      result_o    <= '0;
      ready_o     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i && !annul_i && (opdata2_i != '0)) begin
            cnt_reg     <= '0;
            work_reg    <= {{(WIDTH+1){1'b0}}, dvd_mag};
            divisor_reg <= dvs_mag;
            sdiv_reg    <= signed_div_i;
            sign1_reg   <= opdata1_i[WIDTH-1];
            sign2_reg   <= opdata2_i[WIDTH-1];
          end
        end
        S_DIVZERO: begin
          result_o <= '0;
        end
        S_ON: begin
          if (annul_i) begin
            cnt_reg <= '0;
          end else begin
            work_reg <= step;
            cnt_reg  <= cnt_reg + 5'd1;
            if (last_step) begin
              result_o <= {rem_fix, quot_fix};
            end
          end
        end
        S_END: begin
          if (start_i) begin
            ready_o <= 1'b1;
          end else begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
